// File: rtl/spectro_pkg.sv
// Shared constants and types for the microphone front end and spectrogram stage.
package spectro_pkg;

  localparam int unsigned ADATA_W        = 18;
  localparam int unsigned I2S_FRAME_BITS = 64;
  localparam int unsigned I2S_SLOT_BITS  = 32;
  localparam int unsigned BIT_CNT_W      = $clog2(I2S_FRAME_BITS);

  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } mic_state_e;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit/word clock generator.
// Divides CLK down to BCLK, counts BCLK periods within a 64-bit frame and
// derives WS from the frame position. Rise/fall strobes are asserted in the
// CLK cycle whose posedge performs the corresponding BCLK toggle.
// Ports:
//   CLK, RST  : system clock, synchronous active-high reset
//   bclk      : registered bit clock
//   ws        : registered word select (bit_cnt[5], updated on BCLK fall)
//   bit_cnt   : BCLK falls seen in the current frame, 0..63
//   rise_c    : this cycle's edge toggles bclk 0->1
//   fall_c    : this cycle's edge toggles bclk 1->0
module i2s_clkgen
  import spectro_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 22
) (
  input  logic                 CLK,
  input  logic                 RST,
  output logic                 bclk,
  output logic                 ws,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 rise_c,
  output logic                 fall_c
);

  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0]     div_cnt;
  logic                 tc_c;
  logic [BIT_CNT_W-1:0] bit_cnt_nxt_c;

  assign tc_c          = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign rise_c        = tc_c & ~bclk;
  assign fall_c        = tc_c & bclk;
  assign bit_cnt_nxt_c = bit_cnt + BIT_CNT_W'(1);

  // Half-period divider, BCLK toggle, frame bit counter and WS.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      ws      <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (tc_c) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall_c) begin
        bit_cnt <= bit_cnt_nxt_c;
        ws      <= bit_cnt_nxt_c[BIT_CNT_W-1];
      end
    end
  end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for an 18-bit MEMS microphone.
// Generates BCLK/WS, synchronises SD, shifts in the first 18 bits of the
// selected slot and emits one signed sample per frame once the start-up
// settling frames have elapsed.
// Optional feature: define I2S_DCBLK_EN to pass each sample through a
// first-order DC blocker (adds one CLK of latency).
// Ports:
//   CLK       : system clock
//   RST       : synchronous reset, active-high
//   I2S_BCLK  : bit clock to mic
//   I2S_WS    : word select to mic
//   I2S_SD    : serial data from mic (asynchronous)
//   ADATA0    : signed 18-bit sample, held until next update
//   ADATARDY  : one-CLK strobe, ADATA0 valid in the same cycle
module i2s_mic_rx
  import spectro_pkg::*;
#(
  parameter int unsigned BCLK_DIV       = 22,
  parameter int unsigned CHAN           = 0,
  parameter int unsigned STARTUP_FRAMES = 4096,
  parameter int unsigned DC_SHIFT       = 10
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               I2S_BCLK,
  output logic               I2S_WS,
  input  logic               I2S_SD,
  output logic [ADATA_W-1:0] ADATA0,
  output logic               ADATARDY
);

  localparam int unsigned SU_W = (STARTUP_FRAMES > 1) ? $clog2(STARTUP_FRAMES) : 1;
  localparam logic [BIT_CNT_W-1:0] FIRST_BIT = BIT_CNT_W'(CHAN * I2S_SLOT_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(CHAN * I2S_SLOT_BITS + ADATA_W);

  // Reject configurations the datapath cannot honour.
  if (CHAN > 1 || STARTUP_FRAMES == 0 || BCLK_DIV < 3 ||
      DC_SHIFT == 0 || DC_SHIFT > 31) begin : g_bad_params
    $error("i2s_mic_rx: parameter out of range");
  end

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 rise_c;
  logic                 fall_c;
  logic                 sd_meta;
  logic                 sd_s;
  logic [ADATA_W-1:0]   sreg;
  logic                 shift_c;
  logic                 capture_c;
  logic                 emit_c;
  mic_state_e           state;
  mic_state_e           state_nxt;
  logic [SU_W-1:0]      startup_cnt;
  logic [SU_W-1:0]      startup_cnt_nxt;

  i2s_clkgen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .CLK     (CLK),
    .RST     (RST),
    .bclk    (I2S_BCLK),
    .ws      (I2S_WS),
    .bit_cnt (bit_cnt),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  // Two-flop synchroniser for the mic data line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sd_meta <= 1'b0;
      sd_s    <= 1'b0;
    end else begin
      sd_meta <= I2S_SD;
      sd_s    <= sd_meta;
    end
  end

  // Bit 0 of a slot is the I2S one-BCLK delay; data bits are 1..18.
  assign shift_c   = rise_c && (bit_cnt >= FIRST_BIT) && (bit_cnt <= LAST_BIT);
  assign capture_c = fall_c && (bit_cnt == LAST_BIT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      sreg <= '0;
    end else if (shift_c) begin
      sreg <= {sreg[ADATA_W-2:0], sd_s};
    end
  end

  // Settling / run state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_SETTLE;
      startup_cnt <= '0;
    end else begin
      state       <= state_nxt;
      startup_cnt <= startup_cnt_nxt;
    end
  end

  // Discard STARTUP_FRAMES captures, then emit every capture.
  always_comb begin
    state_nxt       = state;
    startup_cnt_nxt = startup_cnt;
    emit_c          = 1'b0;
    if (capture_c) begin
      case (state)
        ST_SETTLE: begin
          if (startup_cnt == SU_W'(STARTUP_FRAMES - 1)) begin
            state_nxt = ST_RUN;
          end else begin
            startup_cnt_nxt = startup_cnt + SU_W'(1);
          end
        end
        ST_RUN: begin
          emit_c = 1'b1;
        end
        default: begin
          state_nxt = ST_SETTLE;
        end
      endcase
    end
  end

`ifdef I2S_DCBLK_EN
  localparam int unsigned ACC_W = ADATA_W + DC_SHIFT;

  logic signed [ACC_W-1:0]   acc;
  logic signed [ADATA_W-1:0] dc_x;
  logic                      dc_vld;
  logic signed [ADATA_W-1:0] mean_c;
  logic signed [ADATA_W:0]   diff_c;
  logic        [ADATA_W-1:0] y_c;

  // y = x - mean, saturated to the sample width.
  always_comb begin
    mean_c = ADATA_W'(acc >>> DC_SHIFT);
    diff_c = (ADATA_W + 1)'(dc_x) - (ADATA_W + 1)'(mean_c);
    y_c    = diff_c[ADATA_W-1:0];
    if (diff_c[ADATA_W] != diff_c[ADATA_W-1]) begin
      y_c = diff_c[ADATA_W] ? {1'b1, {(ADATA_W-1){1'b0}}} : {1'b0, {(ADATA_W-1){1'b1}}};
    end
  end

  // Capture stage, leaky accumulator and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dc_x     <= '0;
      dc_vld   <= 1'b0;
      acc      <= '0;
      ADATA0   <= '0;
      ADATARDY <= 1'b0;
    end else begin
      dc_vld   <= emit_c;
      ADATARDY <= dc_vld;
      if (emit_c) begin
        dc_x <= sreg;
      end
      if (dc_vld) begin
        acc    <= acc + ACC_W'(diff_c);
        ADATA0 <= y_c;
      end
    end
  end
`else
  // Raw sample straight from the shift register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ADATA0   <= '0;
      ADATARDY <= 1'b0;
    end else begin
      ADATARDY <= emit_c;
      if (emit_c) begin
        ADATA0 <= sreg;
      end
    end
  end
`endif

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: two receivers (left slot, 3 settling frames; right
// slot, 1 settling frame) share one mic model driven from the left unit's
// BCLK/WS. Expected outputs are derived from elapsed CLK count since reset.
module tb_i2s_mic_rx;

  localparam int unsigned D         = 22;
  localparam int unsigned FRAME_CLK = 64 * 2 * D;
`ifdef I2S_DCBLK_EN
  localparam int unsigned LAT = 1;
`else
  localparam int unsigned LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sd;
  logic        bclk0, ws0, rdy0, bclk1, ws1, rdy1;
  logic [17:0] data0, data1;

  always #5 clk = ~clk;

  i2s_mic_rx #(.BCLK_DIV(D), .CHAN(0), .STARTUP_FRAMES(3), .DC_SHIFT(10)) u_left (
    .CLK(clk), .RST(rst), .I2S_BCLK(bclk0), .I2S_WS(ws0), .I2S_SD(sd),
    .ADATA0(data0), .ADATARDY(rdy0));

  i2s_mic_rx #(.BCLK_DIV(D), .CHAN(1), .STARTUP_FRAMES(1), .DC_SHIFT(10)) u_right (
    .CLK(clk), .RST(rst), .I2S_BCLK(bclk1), .I2S_WS(ws1), .I2S_SD(sd),
    .ADATA0(data1), .ADATARDY(rdy1));

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned n       = 0;
  int unsigned fbase   = 0;
  logic        chk_en  = 1'b0;
  logic [17:0] lw [16];
  logic [17:0] rw [16];
  logic [17:0] exp_d [2];
  logic [17:0] g0[$], g1[$];
  int unsigned t0[$], t1[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at n=%0d: got %0d, expected %0d", name, n, act, exp);
    end
  endtask

  // CLK edges since the last reset edge.
  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  // True when the output edge n carries a sample for this slot.
  function automatic bit expect_pulse(input int unsigned chan, input int unsigned su,
                                      output logic [17:0] x);
    int unsigned m, k, fr;
    x = '0;
    if (n < LAT) return 1'b0;
    m = n - LAT;
    if (m == 0 || (m % (2 * D)) != 0) return 1'b0;
    k  = m / (2 * D);
    fr = k / 64;
    if ((k % 64) != chan * 32 + 19 || fr < su) return 1'b0;
    x = (chan != 0) ? rw[(fbase + fr) % 16] : lw[(fbase + fr) % 16];
    return 1'b1;
  endfunction

`ifdef I2S_DCBLK_EN
  longint acc_m [2];

  function automatic logic [17:0] dc_step(input int idx, input logic [17:0] x);
    longint xs, t, d;
    xs = longint'($signed(x));
    t  = acc_m[idx] >>> 10;
    d  = xs - t;
    acc_m[idx] = acc_m[idx] + d;
    if (d > 131071) d = 131071;
    else if (d < -131072) d = -131072;
    return 18'(d);
  endfunction
`endif

  // Mic model: shifts a word MSB-first starting one BCLK after each WS edge.
  int unsigned mpos = 0, mframe = 0;
  logic        pb = 1'b0, pws = 1'b0;
  always @(negedge clk) begin
    logic [17:0] w;
    if (rst) begin
      mpos = 0; mframe = 0; pb = 1'b0; pws = 1'b0; sd = 1'b0;
    end else begin
      if (pb && !bclk0) begin
        if (ws0 != pws) begin
          mpos = 0;
          if (!ws0) mframe++;
        end else begin
          mpos++;
        end
        pws = ws0;
        w = ws0 ? rw[(fbase + mframe) % 16] : lw[(fbase + mframe) % 16];
        if (mpos >= 1 && mpos <= 18) sd = w[18 - mpos];
        else                         sd = 1'($urandom_range(0, 1));
      end
      pb = bclk0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [17:0] x;
    logic        er;
    if (chk_en) begin
      if (n == 0) begin
        exp_d[0] = '0;
        exp_d[1] = '0;
`ifdef I2S_DCBLK_EN
        acc_m[0] = 0;
        acc_m[1] = 0;
`endif
      end
      check("bclk_l", bclk0, (n / D) % 2);
      check("bclk_r", bclk1, (n / D) % 2);
      check("ws_l", ws0, ((n / (2 * D)) % 64) >= 32);
      check("ws_r", ws1, ((n / (2 * D)) % 64) >= 32);
      er = expect_pulse(0, 3, x);
      if (er) begin
`ifdef I2S_DCBLK_EN
        exp_d[0] = dc_step(0, x);
`else
        exp_d[0] = x;
`endif
      end
      check("rdy_l", rdy0, er);
      check("data_l", data0, exp_d[0]);
      er = expect_pulse(1, 1, x);
      if (er) begin
`ifdef I2S_DCBLK_EN
        exp_d[1] = dc_step(1, x);
`else
        exp_d[1] = x;
`endif
      end
      check("rdy_r", rdy1, er);
      check("data_r", data1, exp_d[1]);
    end
  end

  // Record every observed sample for the literal checks.
  always @(negedge clk) begin
    if (chk_en && rdy0) begin g0.push_back(data0); t0.push_back(n); end
    if (chk_en && rdy1) begin g1.push_back(data1); t1.push_back(n); end
  end

  task automatic wait_n(input int unsigned target, input string name);
    int unsigned guard = 0;
    while (n < target && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    check(name, n >= target, 1);
  endtask

  initial begin
    int unsigned cnt;
    lw = '{18'h00001, 18'h3FFFE, 18'h12345, 18'h2ABCD, 18'h20000, 18'h1FFFF, 18'h0F0F0, 18'h00000,
           18'h01000, 18'h01000, 18'h01000, 18'h01000, 18'h00000, 18'h00000, 18'h00000, 18'h00000};
    rw = '{18'h11111, 18'h2DEAD, 18'h0BEEF, 18'h15432, 18'h3FFFF, 18'h00000, 18'h00000, 18'h00000,
           18'h0ACE1, 18'h33333, 18'h1C0DE, 18'h05555, 18'h00000, 18'h00000, 18'h00000, 18'h00000};
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk_en = 1'b1;
    check("rst_bclk", bclk0, 0);
    check("rst_ws", ws0, 0);
    check("rst_data", data0, 0);
    check("rst_rdy", rdy0, 0);
    rst = 1'b0;

    // First BCLK toggle lands BCLK_DIV edges after reset release.
    cnt = 0;
    while (bclk0 !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("first_bclk_edge", cnt, 22);

    // Run into frame 6, bit 10, then reset mid-slot.
    wait_n((6 * 64 + 10) * 2 * D, "timeout_a");
    check("pulses_l_a", g0.size(), 3);
    check("pulses_r_a", g1.size(), 5);
    if (g0.size() >= 3) begin
      check("first_l_time", t0[0], 9284 + LAT);
      check("spacing_l", t0[1] - t0[0], FRAME_CLK);
      check("left_2abcd", g0[0], 18'h2ABCD);
`ifndef I2S_DCBLK_EN
      check("neg_extreme", longint'($signed(g0[1])), -131072);
      check("pos_extreme", longint'($signed(g0[2])), 131071);
`endif
    end
    if (g1.size() >= 5) begin
      check("first_r_time", t1[0], 5060 + LAT);
      check("spacing_r", t1[1] - t1[0], 2816);
`ifndef I2S_DCBLK_EN
      check("right_15432", g1[2], 18'h15432);
`endif
    end

    rst   = 1'b1;
    fbase = 8;
    repeat (3) @(negedge clk);
    check("midrst_bclk", bclk0, 0);
    check("midrst_data", data0, 0);
    check("midrst_rdy", rdy1, 0);
    rst = 1'b0;

    // Full settling delay again after the mid-frame reset.
    wait_n(9284 + 50, "timeout_b");
    check("pulses_l_b", g0.size(), 4);
    check("pulses_r_b", g1.size(), 7);
    if (g0.size() >= 4) begin
      check("restart_l_time", t0[3], 9284 + LAT);
      check("const_01000", g0[3], 18'h01000);
    end
    if (g1.size() >= 6) begin
      check("restart_r_33333", g1[5], 18'h33333);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
